video_timing_gen: RTL and testbench

- Parametrised raster timing generator; successor to the fixed 640x480 timing block inside the GPU (Frame Synthesizer).
- Generates h/v counters, sync, blank and the frameDrawn interrupt for any mode.
- Adds pixel-enable pacing, scaled active coordinates, a programmable scanline interrupt, a frame counter, and a delayed sync/blank copy aligned to renderer pipeline latency.
- Feeds BGWrenderer and the HDMI/NTSC encoders.

---
 rtl/video_timing_gen_if.sv | 39 +++
 rtl/video_timing_gen.sv | 165 ++++++++++++++++
 tb/tb_video_timing_gen.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/video_timing_gen_if.sv
// Bundle of pacing, interrupt-control and raster outputs between the timing
// generator (master) and its consumers (slave).
interface video_timing_gen_if #(
    parameter int CW = 12
);
    logic          pix_en;
    logic [CW-1:0] irq_line;
    logic          irq_en;
    logic [CW-1:0] h_count;
    logic [CW-1:0] v_count;
    logic [CW-1:0] x_pix;
    logic [CW-1:0] y_pix;
    logic          hsync;
    logic          vsync;
    logic          csync;
    logic          blank;
    logic          hsync_d;
    logic          vsync_d;
    logic          blank_d;
    logic          frameDrawn;
    logic          line_irq;
    logic [15:0]   frame_count;

    modport master (
        input  pix_en, irq_line, irq_en,
        output h_count, v_count, x_pix, y_pix,
        output hsync, vsync, csync, blank,
        output hsync_d, vsync_d, blank_d,
        output frameDrawn, line_irq, frame_count
    );

    modport slave (
        output pix_en, irq_line, irq_en,
        input  h_count, v_count, x_pix, y_pix,
        input  hsync, vsync, csync, blank,
        input  hsync_d, vsync_d, blank_d,
        input  frameDrawn, line_irq, frame_count
    );
endinterface

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: h/v counters, sync/blank decodes,
// scaled coordinates, frame/scanline interrupts and a pipeline-aligned sync copy.
module video_timing_gen #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int HS_POL      = 0,
    parameter int VS_POL      = 0,
    parameter int CW          = 12,
    parameter int SCALE_SHIFT = 1,
    parameter int PIPE        = 2
) (
    input logic                clk,
    input logic                reset,
    video_timing_gen_if.master vif
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] V_FD     = CW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic          HS_ON    = 1'(HS_POL);
    localparam logic          VS_ON    = 1'(VS_POL);
    localparam int unsigned   NSTAGE   = PIPE;

    logic [CW-1:0] h_q, h_d, v_q, v_d;
    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic [CW-1:0] irq_line_q, irq_line_d;
    logic          irq_en_q, irq_en_d;
    logic          hs_q, hs_d, vs_q, vs_d, cs_q, cs_d;
    logic          blk_q, blk_d;
    logic          fd_q, fd_d, li_q, li_d;
    logic [15:0]   fcnt_q, fcnt_d;
    logic          hs_raw, vs_raw;

    // Decodes are evaluated on the next counter values so every output
    // changes on the same enabled edge as h/v.
    always_comb begin
        h_d        = h_q;
        v_d        = v_q;
        x_d        = x_q;
        y_d        = y_q;
        irq_line_d = irq_line_q;
        irq_en_d   = irq_en_q;
        hs_d       = hs_q;
        vs_d       = vs_q;
        cs_d       = cs_q;
        blk_d      = blk_q;
        fcnt_d     = fcnt_q;
        fd_d       = 1'b0;
        li_d       = 1'b0;
        hs_raw     = 1'b0;
        vs_raw     = 1'b0;
        if (vif.pix_en) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
            hs_raw = (h_d >= HS_START) && (h_d < HS_END);
            vs_raw = (v_d >= VS_START) && (v_d < VS_END);
            blk_d  = (h_d >= H_ACT) || (v_d >= V_ACT);
            hs_d   = hs_raw ? HS_ON : ~HS_ON;
            vs_d   = vs_raw ? VS_ON : ~VS_ON;
            cs_d   = (hs_raw ^ vs_raw) ? HS_ON : ~HS_ON;
            x_d    = blk_d ? '0 : (h_d >> SCALE_SHIFT);
            y_d    = blk_d ? '0 : (v_d >> SCALE_SHIFT);
            // The frame's irq settings are captured on entry to (0,0) and
            // already govern line 0 of that frame.
            if (h_d == '0 && v_d == '0) begin
                irq_line_d = vif.irq_line;
                irq_en_d   = vif.irq_en;
            end
            fd_d = (h_d == H_ACT) && (v_d == V_FD);
            if (fd_d) begin
                fcnt_d = fcnt_q + 16'd1;
            end
            li_d = irq_en_d && (h_d == '0) && (v_d == irq_line_d);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_q        <= '0;
            v_q        <= '0;
            x_q        <= '0;
            y_q        <= '0;
            irq_line_q <= '0;
            irq_en_q   <= 1'b0;
            hs_q       <= ~HS_ON;
            vs_q       <= ~VS_ON;
            cs_q       <= ~HS_ON;
            blk_q      <= 1'b0;
            fd_q       <= 1'b0;
            li_q       <= 1'b0;
            fcnt_q     <= '0;
        end else begin
            h_q        <= h_d;
            v_q        <= v_d;
            x_q        <= x_d;
            y_q        <= y_d;
            irq_line_q <= irq_line_d;
            irq_en_q   <= irq_en_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            cs_q       <= cs_d;
            blk_q      <= blk_d;
            fd_q       <= fd_d;
            li_q       <= li_d;
            fcnt_q     <= fcnt_d;
        end
    end

    generate
        if (PIPE == 0) begin : g_nopipe
            assign vif.hsync_d = hs_q;
            assign vif.vsync_d = vs_q;
            assign vif.blank_d = blk_q;
        end else begin : g_pipe
            logic [2:0] pipe_q [NSTAGE];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int unsigned i = 0; i < NSTAGE; i++) begin
                        pipe_q[i] <= {~HS_ON, ~VS_ON, 1'b1};
                    end
                end else if (vif.pix_en) begin
                    pipe_q[0] <= {hs_q, vs_q, blk_q};
                    for (int unsigned i = 1; i < NSTAGE; i++) begin
                        pipe_q[i] <= pipe_q[i-1];
                    end
                end
            end

            assign vif.hsync_d = pipe_q[NSTAGE-1][2];
            assign vif.vsync_d = pipe_q[NSTAGE-1][1];
            assign vif.blank_d = pipe_q[NSTAGE-1][0];
        end
    endgenerate

    assign vif.h_count     = h_q;
    assign vif.v_count     = v_q;
    assign vif.x_pix       = x_q;
    assign vif.y_pix       = y_q;
    assign vif.hsync       = hs_q;
    assign vif.vsync       = vs_q;
    assign vif.csync       = cs_q;
    assign vif.blank       = blk_q;
    assign vif.frameDrawn  = fd_q;
    assign vif.line_irq    = li_q;
    assign vif.frame_count = fcnt_q;
endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a reduced raster: two instances (PIPE=2 active-low
// syncs, PIPE=0 active-high syncs) checked every cycle against a step-count model.
module tb_video_timing_gen;
    localparam int HA  = 16;
    localparam int HFP = 2;
    localparam int HSW = 3;
    localparam int HBP = 3;
    localparam int VA  = 8;
    localparam int VFP = 1;
    localparam int VSW = 2;
    localparam int VBP = 1;
    localparam int HT  = HA + HFP + HSW + HBP;
    localparam int VT  = VA + VFP + VSW + VBP;
    localparam int FRAME  = HT * VT;
    localparam int TO_FD  = (VA - 1) * HT + HA;

    logic clk;
    logic reset;
    logic pix_en;
    logic irq_en;
    logic [11:0] irq_line;
    int pace;
    int cyc;
    int n_checks;
    int n_fail;
    int irq_cnt;

    int m_n, m_ll;
    bit m_st, m_le;
    logic [127:0] qa[$];
    logic [127:0] qb[$];

    video_timing_gen_if #(.CW(12)) ifa ();
    video_timing_gen_if #(.CW(12)) ifb ();

    assign ifa.pix_en   = pix_en;
    assign ifa.irq_en   = irq_en;
    assign ifa.irq_line = irq_line;
    assign ifb.pix_en   = pix_en;
    assign ifb.irq_en   = irq_en;
    assign ifb.irq_line = irq_line;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(0), .VS_POL(0), .CW(12), .SCALE_SHIFT(1), .PIPE(2)
    ) dut_a (
        .clk(clk), .reset(reset), .vif(ifa)
    );

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(1), .VS_POL(1), .CW(12), .SCALE_SHIFT(2), .PIPE(0)
    ) dut_b (
        .clk(clk), .reset(reset), .vif(ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] pk(
        logic [11:0] h, logic [11:0] v, logic [11:0] x, logic [11:0] y,
        logic hs, logic vs, logic cs, logic bl,
        logic hsd, logic vsd, logic bld, logic fd, logic li, logic [15:0] fc);
        return {55'd0, h, v, x, y, hs, vs, cs, bl, hsd, vsd, bld, fd, li, fc};
    endfunction

    // {hsync, vsync, blank} for the raster position reached after n steps
    function automatic logic [2:0] dec(int n, bit hp, bit vp);
        int h, v;
        bit hr, vr;
        h  = n % HT;
        v  = (n / HT) % VT;
        hr = (h >= HA + HFP) && (h < HA + HFP + HSW);
        vr = (v >= VA + VFP) && (v < VA + VFP + VSW);
        return {hr ? hp : !hp, vr ? vp : !vp, (h >= HA) || (v >= VA)};
    endfunction

    function automatic logic [127:0] expv(int n, bit st, int ll, bit le,
                                          bit hp, bit vp, int ss, int pipe);
        int h, v, fc;
        bit hr, vr, blk;
        logic [2:0] cur, dl;
        h   = n % HT;
        v   = (n / HT) % VT;
        hr  = (h >= HA + HFP) && (h < HA + HFP + HSW);
        vr  = (v >= VA + VFP) && (v < VA + VFP + VSW);
        cur = dec(n, hp, vp);
        blk = cur[0];
        if (pipe == 0)     dl = cur;
        else if (n < pipe) dl = {!hp, !vp, 1'b1};
        else               dl = dec(n - pipe, hp, vp);
        fc = (n >= TO_FD) ? ((n - TO_FD) / FRAME + 1) : 0;
        return pk(12'(h), 12'(v), 12'(blk ? 0 : (h >> ss)), 12'(blk ? 0 : (v >> ss)),
                  cur[2], cur[1], (hr ^ vr) ? hp : !hp, blk,
                  dl[2], dl[1], dl[0],
                  st && (h == HA) && (v == VA - 1),
                  st && le && (h == 0) && (v == ll),
                  16'(fc));
    endfunction

    function automatic logic [127:0] act_a();
        return pk(ifa.h_count, ifa.v_count, ifa.x_pix, ifa.y_pix,
                  ifa.hsync, ifa.vsync, ifa.csync, ifa.blank,
                  ifa.hsync_d, ifa.vsync_d, ifa.blank_d,
                  ifa.frameDrawn, ifa.line_irq, ifa.frame_count);
    endfunction

    function automatic logic [127:0] act_b();
        return pk(ifb.h_count, ifb.v_count, ifb.x_pix, ifb.y_pix,
                  ifb.hsync, ifb.vsync, ifb.csync, ifb.blank,
                  ifb.hsync_d, ifb.vsync_d, ifb.blank_d,
                  ifb.frameDrawn, ifb.line_irq, ifb.frame_count);
    endfunction

    // Model: advance on each rising edge and queue what the DUTs must show.
    initial forever begin
        @(posedge clk);
        cyc++;
        if (reset) begin
            m_n = 0; m_st = 0; m_ll = 0; m_le = 0;
        end else if (pix_en) begin
            m_n++;
            m_st = 1;
            if (m_n % FRAME == 0) begin
                m_ll = int'(irq_line);
                m_le = irq_en;
            end
        end else begin
            m_st = 0;
        end
        qa.push_back(expv(m_n, m_st, m_ll, m_le, 1'b0, 1'b0, 1, 2));
        qb.push_back(expv(m_n, m_st, m_ll, m_le, 1'b1, 1'b1, 2, 0));
    end

    initial forever begin
        @(negedge clk);
        if (qa.size() > 0) begin
            chk("sb_a", act_a(), qa.pop_front());
            chk("sb_b", act_b(), qb.pop_front());
        end
    end

    initial forever begin
        @(negedge clk);
        if (ifa.line_irq) irq_cnt++;
        if (!reset && ifa.h_count == 12'(HA - 1) && ifa.v_count == 12'(VA - 1))
            chk("xy_last_active", 128'({ifa.x_pix, ifa.y_pix}),
                128'({12'((HA - 1) >> 1), 12'((VA - 1) >> 1)}));
        if (!reset && ifa.h_count == 12'(HA) && ifa.v_count == 12'(VA - 1))
            chk("x_blank", 128'(ifa.x_pix), 128'(0));
    end

    initial forever begin
        @(negedge clk);
        case (pace)
            0:       pix_en = 1'b1;
            1:       pix_en = !pix_en;
            default: pix_en = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic wait_pulse(input bit want_irq, input int bound, output int c, output int vv);
        c  = -1;
        vv = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (want_irq ? ifa.line_irq : ifa.frameDrawn) begin
                c  = cyc;
                vv = int'(ifa.v_count);
                return;
            end
        end
    endtask

    task automatic wait_line(input int line, input int bound);
        for (int i = 0; i < bound && int'(ifa.v_count) != line; i++) @(negedge clk);
    endtask

    initial begin
        int rel, c1, c2, v1, v2;
        logic [127:0] rst_a, rst_b;
        n_checks = 0; n_fail = 0; cyc = 0; irq_cnt = 0;
        pace = 0; pix_en = 1'b0;
        reset = 1'b1; irq_en = 1'b1; irq_line = 12'd5;
        rst_a = expv(0, 0, 0, 0, 1'b0, 1'b0, 1, 2);
        rst_b = expv(0, 0, 0, 0, 1'b1, 1'b1, 2, 0);
        repeat (3) @(negedge clk);
        chk("reset_a", act_a(), rst_a);
        chk("reset_b", act_b(), rst_b);
        #1 reset = 1'b0;
        rel = cyc;

        wait_pulse(1'b0, 2 * FRAME, c1, v1);
        chk("first_fd_steps", 128'(c1 - rel), 128'(TO_FD));
        chk("fd_line", 128'(v1), 128'(VA - 1));
        wait_pulse(1'b0, 2 * FRAME, c2, v2);
        chk("frame_period", 128'(c2 - c1), 128'(FRAME));
        chk("frame_count", 128'(ifa.frame_count), 128'(2));

        wait_line(2, 2 * FRAME);
        irq_line = 12'd9;
        wait_pulse(1'b1, 2 * FRAME, c1, v1);
        chk("irq_old_line", 128'(v1), 128'(5));
        wait_pulse(1'b1, 2 * FRAME, c2, v2);
        chk("irq_new_line", 128'(v2), 128'(9));
        chk("irq_gap", 128'(c2 - c1), 128'((VT - 5 + 9) * HT));

        irq_line = 12'(VT + 8);
        wait_pulse(1'b0, 2 * FRAME, c1, v1);
        wait_pulse(1'b0, 2 * FRAME, c1, v1);
        irq_cnt = 0;
        repeat (2 * FRAME) @(negedge clk);
        chk("irq_out_of_range", 128'(irq_cnt), 128'(0));

        irq_line = 12'd3;
        pace = 1;
        wait_pulse(1'b0, 3 * FRAME, c1, v1);
        wait_pulse(1'b0, 3 * FRAME, c2, v2);
        chk("period_half_rate", 128'(c2 - c1), 128'(2 * FRAME));

        pace = 2;
        repeat (3 * FRAME) @(negedge clk);

        pace = 0;
        wait_line(6, 4 * FRAME);
        #1 reset = 1'b1;
        #1;
        chk("async_reset_a", act_a(), rst_a);
        chk("async_reset_b", act_b(), rst_b);
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        rel = cyc;
        wait_pulse(1'b0, 2 * FRAME, c1, v1);
        chk("fd_after_reset", 128'(c1 - rel), 128'(TO_FD));
        chk("fcnt_after_reset", 128'(ifa.frame_count), 128'(1));

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
